// File: rtl/tag_store_sa.sv
// rtl/tag_store_sa.sv - set-associative tag store with registered lookup, victim select and sequenced flush
module tag_store_sa #(
  parameter int TAG_W = 24,
  parameter int WAYS  = 8,
  parameter int SETS  = 16,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAYS-1:0]  rsp_hit_way,
  output logic [WAYS-1:0]  rsp_victim_way,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WAYS-1:0]  wr_way,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx,
  input  logic [WAYS-1:0]  inv_way,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             err_multi_hit
);

  localparam int RR_W = $clog2(WAYS);
  localparam logic [RR_W-1:0]  RR_MAX   = RR_W'(WAYS - 1);
  localparam logic [RR_W-1:0]  RR_ONE   = RR_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SETS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [WAYS-1:0]  WAY_ONE  = WAYS'(1);

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } state_t;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [RR_W-1:0]  rr_q    [SETS];

  state_t           state_q;
  logic [IDX_W-1:0] flush_cnt_q;

  logic [WAYS-1:0]  hit_vec;
  logic [WAYS-1:0]  victim_vec;
  logic             victim_found;
  logic             multi_hit;
  logic             lk_accept;
  logic             upd_ok;

  // Requests are only honoured while idle; everything is dropped during a flush.
  assign lk_ready  = ~flush_busy;
  assign upd_ok    = (state_q == ST_IDLE);
  assign lk_accept = lk_valid && upd_ok;

  // Match and victim selection on the pre-edge contents of the addressed set.
  always_comb begin
    hit_vec      = '0;
    victim_vec   = '0;
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_q[lk_idx][w]) begin
        victim_vec[w] = 1'b1;
        victim_found  = 1'b1;
      end
    end
    if (!victim_found) begin
      victim_vec = WAY_ONE << rr_q[lk_idx];
    end
    multi_hit = |(hit_vec & (hit_vec - WAY_ONE));
  end

  // Lookup response register; fields hold when no lookup is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid      <= 1'b0;
      rsp_hit        <= 1'b0;
      rsp_hit_way    <= '0;
      rsp_victim_way <= '0;
      err_multi_hit  <= 1'b0;
    end else begin
      rsp_valid <= lk_accept;
      if (lk_accept) begin
        rsp_hit        <= |hit_vec;
        rsp_hit_way    <= hit_vec;
        rsp_victim_way <= victim_vec;
        if (multi_hit) begin
          err_multi_hit <= 1'b1;
        end
      end
    end
  end

  // Valid bits: write beats invalidate on the same entry; flush wipes one set per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else if (upd_ok) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          if (wr_en && (wr_idx == IDX_W'(s)) && wr_way[w]) begin
            valid_q[s][w] <= 1'b1;
          end else if (inv_en && (inv_idx == IDX_W'(s)) && inv_way[w]) begin
            valid_q[s][w] <= 1'b0;
          end
        end
      end
    end else begin
      valid_q[flush_cnt_q] <= '0;
    end
  end

  // Tag storage; tags survive invalidate and flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
        end
      end
    end else if (upd_ok && wr_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (wr_way[w]) begin
          tag_q[wr_idx][w] <= wr_tag;
        end
      end
    end
  end

  // Round-robin pointer advances when the write covers the way it points at.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
      end
    end else if (upd_ok) begin
      if (wr_en && wr_way[rr_q[wr_idx]]) begin
        rr_q[wr_idx] <= (rr_q[wr_idx] == RR_MAX) ? '0 : rr_q[wr_idx] + RR_ONE;
      end
    end else begin
      rr_q[flush_cnt_q] <= '0;
    end
  end

  // Flush sequencer: walks every set once, busy for exactly SETS cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      flush_busy  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush_req) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= '0;
            flush_busy  <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == IDX_LAST) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            flush_busy  <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q + IDX_ONE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          flush_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tag_store_sa.sv
// tb/tb_tag_store_sa.sv - self-checking bench for tag_store_sa
module tb_tag_store_sa;

  localparam int TAG_W = 24;
  localparam int WAYS  = 8;
  localparam int SETS  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lk_valid = 1'b0;
  logic        lk_ready;
  logic [3:0]  lk_idx = '0;
  logic [23:0] lk_tag = '0;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [7:0]  rsp_hit_way;
  logic [7:0]  rsp_victim_way;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_idx = '0;
  logic [7:0]  wr_way = '0;
  logic [23:0] wr_tag = '0;
  logic        inv_en = 1'b0;
  logic [3:0]  inv_idx = '0;
  logic [7:0]  inv_way = '0;
  logic        flush_req = 1'b0;
  logic        flush_busy;
  logic        err_multi_hit;

  tag_store_sa #(.TAG_W(TAG_W), .WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .reset(reset),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_idx(lk_idx), .lk_tag(lk_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_hit_way(rsp_hit_way),
    .rsp_victim_way(rsp_victim_way),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_way(wr_way), .wr_tag(wr_tag),
    .inv_en(inv_en), .inv_idx(inv_idx), .inv_way(inv_way),
    .flush_req(flush_req), .flush_busy(flush_busy), .err_multi_hit(err_multi_hit)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain arrays of entries plus a per-set replacement counter.
  bit          m_valid [SETS][WAYS];
  logic [23:0] m_tag   [SETS][WAYS];
  int          m_rr    [SETS];
  bit          m_err;

  typedef struct {
    logic        lv;
    logic [3:0]  li;
    logic [23:0] lt;
    logic        we;
    logic [3:0]  wi;
    logic [7:0]  ww;
    logic [23:0] wt;
    logic        ie;
    logic [3:0]  ii;
    logic [7:0]  iw;
    logic [7:0]  hw;
    logic [7:0]  vic;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic lv, logic [3:0] li, logic [23:0] lt,
                              logic we, logic [3:0] wi, logic [7:0] ww, logic [23:0] wt,
                              logic ie, logic [3:0] ii, logic [7:0] iw,
                              logic [7:0] hw, logic [7:0] vic);
    vec_t v;
    v.lv = lv; v.li = li; v.lt = lt;
    v.we = we; v.wi = wi; v.ww = ww; v.wt = wt;
    v.ie = ie; v.ii = ii; v.iw = iw;
    v.hw = hw; v.vic = vic;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_tag[s][w]   = '0;
      end
    end
    m_err = 0;
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
    end
  endfunction

  function automatic void model_lookup(input logic [3:0] li, input logic [23:0] lt,
                                       output logic [7:0] hw, output logic [7:0] vic);
    int first_inv = -1;
    hw = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (m_valid[li][w] && m_tag[li][w] == lt) hw[w] = 1'b1;
      if (first_inv < 0 && !m_valid[li][w]) first_inv = w;
    end
    vic = '0;
    if (first_inv >= 0) vic[first_inv] = 1'b1;
    else vic[m_rr[li]] = 1'b1;
  endfunction

  function automatic void model_update(input logic we, input logic [3:0] wi, input logic [7:0] ww,
                                       input logic [23:0] wt, input logic ie, input logic [3:0] ii,
                                       input logic [7:0] iw);
    int rr;
    if (ie) for (int w = 0; w < WAYS; w++) if (iw[w]) m_valid[ii][w] = 0;
    if (we) begin
      rr = m_rr[wi];
      for (int w = 0; w < WAYS; w++) begin
        if (ww[w]) begin
          m_valid[wi][w] = 1;
          m_tag[wi][w]   = wt;
        end
      end
      if (ww[rr]) m_rr[wi] = (rr + 1) % WAYS;
    end
  endfunction

  // One idle-state cycle: expectations come from the model's pre-edge view.
  task automatic do_cycle(input vec_t v, output logic [7:0] ehw, output logic [7:0] evic);
    ehw = '0;
    evic = '0;
    if (v.lv) begin
      model_lookup(v.li, v.lt, ehw, evic);
      if ($countones(ehw) > 1) m_err = 1;
    end
    lk_valid = v.lv; lk_idx = v.li; lk_tag = v.lt;
    wr_en = v.we; wr_idx = v.wi; wr_way = v.ww; wr_tag = v.wt;
    inv_en = v.ie; inv_idx = v.ii; inv_way = v.iw;
    model_update(v.we, v.wi, v.ww, v.wt, v.ie, v.ii, v.iw);
    step();
    lk_valid = 0; wr_en = 0; inv_en = 0;
  endtask

  task automatic check_resp(input string tag_name, input logic [7:0] hw, input logic [7:0] vic);
    chk({tag_name, ".rsp_valid"}, rsp_valid, 1);
    chk({tag_name, ".rsp_hit"}, rsp_hit, |hw);
    chk({tag_name, ".hit_way"}, rsp_hit_way, hw);
    chk({tag_name, ".victim"}, rsp_victim_way, vic);
  endtask

  initial begin
    logic [7:0] ehw, evic;
    int busy_cnt;
    vec_t v;

    model_clear();
    reset = 0;
    repeat (2) step();
    reset = 1;
    step();

    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_hit", rsp_hit, 0);
    chk("rst.hit_way", rsp_hit_way, 0);
    chk("rst.victim", rsp_victim_way, 0);
    chk("rst.flush_busy", flush_busy, 0);
    chk("rst.err", err_multi_hit, 0);
    chk("rst.lk_ready", lk_ready, 1);

    // Directed vectors with hand-derived expectations.
    tbl.push_back(mk(1, 3, 24'hABCDEF, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01));
    tbl.push_back(mk(0, 0, 0, 1, 3, 8'h04, 24'hABCDEF, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 3, 24'hABCDEF, 0, 0, 0, 0, 0, 0, 0, 8'h04, 8'h01));
    for (int w = 0; w < 8; w++)
      tbl.push_back(mk(0, 0, 0, 1, 5, 8'(1 << w), 24'(16 + w), 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 5, 24'h99, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01));
    tbl.push_back(mk(1, 5, 24'h13, 0, 0, 0, 0, 0, 0, 0, 8'h08, 8'h01));
    tbl.push_back(mk(0, 0, 0, 1, 5, 8'h01, 24'h20, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 5, 24'h99, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h02));
    for (int w = 1; w < 8; w++)
      tbl.push_back(mk(0, 0, 0, 1, 5, 8'(1 << w), 24'(16 + w), 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 5, 24'h99, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01));
    tbl.push_back(mk(1, 2, 24'h55, 1, 2, 8'h01, 24'h55, 0, 0, 0, 8'h00, 8'h01));
    tbl.push_back(mk(1, 2, 24'h55, 0, 0, 0, 0, 0, 0, 0, 8'h01, 8'h02));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 8'h10, 8'h00, 8'h00));
    tbl.push_back(mk(1, 5, 24'h14, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h10));
    tbl.push_back(mk(0, 0, 0, 1, 5, 8'h10, 24'h14, 1, 5, 8'h10, 8'h00, 8'h00));
    tbl.push_back(mk(1, 5, 24'h14, 0, 0, 0, 0, 0, 0, 0, 8'h10, 8'h01));

    for (int i = 0; i < tbl.size(); i++) begin
      do_cycle(tbl[i], ehw, evic);
      if (tbl[i].lv) check_resp($sformatf("tbl%0d", i), tbl[i].hw, tbl[i].vic);
      else chk($sformatf("tbl%0d.rsp_valid", i), rsp_valid, 0);
    end

    // Flush: populate every set, then a lookup in the flush_req cycle still completes.
    for (int s = 0; s < SETS; s++)
      do_cycle(mk(0, 0, 0, 1, 4'(s), 8'h01, 24'(256 + s), 0, 0, 0, 0, 0), ehw, evic);
    model_lookup(4'd0, 24'h100, ehw, evic);
    flush_req = 1; lk_valid = 1; lk_idx = 0; lk_tag = 24'h100;
    step();
    flush_req = 0; lk_valid = 0;
    check_resp("flush_edge", ehw, evic);
    model_flush();
    busy_cnt = 0;
    while (flush_busy && busy_cnt < 100) begin
      busy_cnt++;
      chk("flush.lk_ready", lk_ready, 0);
      if (busy_cnt == 5) begin
        lk_valid = 1; lk_idx = 7; lk_tag = 24'h107;
        wr_en = 1; wr_idx = 7; wr_way = 8'h01; wr_tag = 24'h107;
        inv_en = 1; inv_idx = 1; inv_way = 8'hFF; flush_req = 1;
      end
      step();
      lk_valid = 0; wr_en = 0; inv_en = 0; flush_req = 0;
      chk("flush.rsp_valid", rsp_valid, 0);
    end
    chk("flush.busy_cycles", busy_cnt, SETS);
    for (int s = 0; s < SETS; s++) begin
      do_cycle(mk(1, 4'(s), 24'(256 + s), 0, 0, 0, 0, 0, 0, 0, 0, 0), ehw, evic);
      check_resp($sformatf("post_flush%0d", s), 8'h00, 8'h01);
    end

    // Multi-hit is sticky across clean lookups.
    do_cycle(mk(0, 0, 0, 1, 0, 8'h42, 24'h77, 0, 0, 0, 0, 0), ehw, evic);
    do_cycle(mk(1, 0, 24'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0), ehw, evic);
    check_resp("multi", 8'h42, 8'h01);
    chk("multi.err", err_multi_hit, 1);
    do_cycle(mk(1, 0, 24'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0), ehw, evic);
    check_resp("clean", 8'h00, 8'h01);
    chk("clean.err", err_multi_hit, 1);

    // Reset mid-flush clears outputs without a clock edge.
    flush_req = 1;
    step();
    flush_req = 0;
    repeat (2) step();
    chk("midflush.busy", flush_busy, 1);
    reset = 0;
    #1;
    chk("arst.rsp_valid", rsp_valid, 0);
    chk("arst.rsp_hit", rsp_hit, 0);
    chk("arst.hit_way", rsp_hit_way, 0);
    chk("arst.victim", rsp_victim_way, 0);
    chk("arst.flush_busy", flush_busy, 0);
    chk("arst.err", err_multi_hit, 0);
    model_clear();
    repeat (2) step();
    reset = 1;
    step();
    chk("arst.idle_ready", lk_ready, 1);

    // Randomised traffic on a few sets and tags against the model.
    for (int i = 0; i < 600; i++) begin
      v = mk($urandom_range(0, 1), 4'($urandom_range(0, 3)), 24'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7)),
             24'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 3)), 8'($urandom), 0, 0);
      do_cycle(v, ehw, evic);
      chk("rnd.rsp_valid", rsp_valid, v.lv);
      if (v.lv) begin
        chk("rnd.hit", rsp_hit, |ehw);
        chk("rnd.hit_way", rsp_hit_way, ehw);
        chk("rnd.victim", rsp_victim_way, evic);
      end
      chk("rnd.err", err_multi_hit, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tag_store_sa.md
Name: tag_store_sa

Overview:
- Parametrised successor to the fixed 8-way x 24-bit tag array for the cache subsystem.
- Holds SETS x WAYS tag entries, each with a valid bit.
- Provides a one-cycle registered lookup with hit and victim selection, per-way write and invalidate, and a sequenced flush.
- Sits between the cache controller FSM and the data array; the controller consumes the hit way and victim way.

Parameters:
- TAG_W, 24, tag width in bits.
- WAYS, 8, associativity (>=2).
- SETS, 16, number of sets (>=2, power of 2).
- IDX_W, $clog2(SETS), set index width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- lk_valid  in  1  lookup request.
- lk_ready  out  1  lookup accepted; equals !flush_busy.
- lk_idx  in  IDX_W  lookup set.
- lk_tag  in  TAG_W  lookup tag.
- rsp_valid  out  1  lookup result valid.
- rsp_hit  out  1  any valid way matched.
- rsp_hit_way  out  WAYS  one-hot (multi-hot on error) matching ways.
- rsp_victim_way  out  WAYS  one-hot replacement candidate.
- wr_en  in  1  tag write.
- wr_idx  in  IDX_W  write set.
- wr_way  in  WAYS  way select mask.
- wr_tag  in  TAG_W  tag to write.
- inv_en  in  1  single-entry invalidate.
- inv_idx  in  IDX_W  invalidate set.
- inv_way  in  WAYS  invalidate way mask.
- flush_req  in  1  start full invalidate.
- flush_busy  out  1  flush in progress.
- err_multi_hit  out  1  sticky; set when a lookup matches more than one valid way.

Behaviour:
- Reset (reset=0, asynchronous):
  - All valid bits, tags and round-robin pointers (rr_ptr[s]) cleared to 0.
  - FSM to IDLE.
  - rsp_valid, rsp_hit, rsp_hit_way, rsp_victim_way, flush_busy and err_multi_hit all 0.
  - Reset asserted mid-flush aborts to IDLE with all state cleared.
- Lookup (latency 1):
  - lk_valid && lk_ready at edge N gives rsp_valid=1 for exactly the cycle after N; rsp_valid=0 in cycles with no accepted lookup.
  - rsp_hit_way[w] = valid[idx][w] && tag[idx][w]==lk_tag; rsp_hit = |rsp_hit_way.
  - Victim: the lowest-index invalid way of the set if any exists, else one-hot of rr_ptr[idx]. The victim is reported even on a hit.
  - err_multi_hit is set if popcount(rsp_hit_way) > 1 and is cleared only by reset.
  - Response fields hold their last values while rsp_valid=0.
- Write:
  - wr_en sets valid=1 and tag=wr_tag in every way selected by wr_way; wr_way=0 is a no-op.
  - If wr_way[rr_ptr[wr_idx]]=1, rr_ptr[wr_idx] increments mod WAYS.
- Invalidate: inv_en clears valid for the selected ways; tags and rr_ptr are unchanged.
- Same-cycle interactions:
  - A lookup, write and invalidate may all occur in one cycle.
  - A lookup samples pre-edge contents (read-before-write); this applies to both hit and victim.
  - If write and invalidate target the same entry, the write wins (valid=1).
- Flush FSM:
  - IDLE: flush_req=1 -> FLUSH, counter=0, flush_busy=1 from the next cycle.
  - FLUSH: each cycle clears all valid bits and rr_ptr of set[counter], then counter++. After set SETS-1 is cleared -> IDLE.
  - flush_busy is high for exactly SETS cycles.
  - During FLUSH: lk_ready=0, and lk_valid, wr_en, inv_en and flush_req are ignored (dropped, no response).
  - A lookup accepted in the cycle flush_req is sampled still completes normally on the next cycle.
- Arithmetic:
  - rr_ptr is $clog2(WAYS) bits and wraps WAYS-1 -> 0; for non-power-of-2 WAYS the wrap is an explicit compare.
  - The flush counter is IDX_W bits; termination is detected at SETS-1, not by overflow.

Test Plan:
1. Reset, then lookup idx=3 tag=0xABCDEF -> next cycle rsp_valid=1, rsp_hit=0, rsp_victim_way=8'h01.
2. Write idx=3 way=8'h04 tag=0xABCDEF, then lookup the same -> rsp_hit=1, rsp_hit_way=8'h04, rsp_victim_way=8'h01.
3. Fill all 8 ways of idx=5 (ways 0..7 in order, tags 0x10..0x17), then lookup tag 0x99 -> hit=0, victim=8'h01. Then write way 0 -> the next miss gives victim=8'h02. Wrap check: after writing way 7, victim=8'h01.
4. Same-cycle write idx=2 way=8'h01 tag=0x55 with lookup idx=2 tag=0x55 -> rsp_hit=0. A repeat lookup next cycle -> rsp_hit=1.
5. Populate sets 0..15, pulse flush_req -> flush_busy=1 for exactly 16 cycles and lk_ready=0 throughout. A lookup issued mid-flush gets no rsp_valid. After the flush, every lookup misses with victim=8'h01.
6. Write tag 0x77 into ways 1 and 6 of idx=0 via wr_way=8'h42, then lookup -> rsp_hit_way=8'h42 and err_multi_hit=1, which stays set after later clean lookups. Assert reset mid-flush -> all outputs 0 immediately, with no clock edge required.
